// File: rtl/cla_32bits.sv
// Two-level carry-lookahead adder: eight 4-bit lookahead groups, two 4-group
// halves with their own lookahead, and a top-level combine for the carry out.
module cla_32bits #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic [WIDTH-1:0] s_r,
  output logic             co_r
);

  localparam int GROUPS = WIDTH / 4;

  logic [WIDTH-1:0]  g;
  logic [WIDTH-1:0]  p;
  logic [WIDTH-1:0]  c;
  logic [GROUPS-1:0] grp_g;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS-1:0] grp_c;
  logic              half_g0;
  logic              half_p0;
  logic              half_g1;
  logic              half_p1;

  assign g = a & b;
  assign p = a ^ b;
  assign s = p ^ c;

  // First level: in-group carries are flattened from the group carry-in.
  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_group
    logic [3:0] gb;
    logic [3:0] pb;
    logic       cin;

    assign gb  = g[4*gi +: 4];
    assign pb  = p[4*gi +: 4];
    assign cin = grp_c[gi];

    assign c[4*gi]     = cin;
    assign c[4*gi + 1] = gb[0] | (pb[0] & cin);
    assign c[4*gi + 2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    assign c[4*gi + 3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                       | (pb[2] & pb[1] & pb[0] & cin);

    assign grp_g[gi] = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
                     | (pb[3] & pb[2] & pb[1] & gb[0]);
    assign grp_p[gi] = &pb;
  end

  // Second level: each half looks ahead from its own carry-in, so the lower
  // half's carry-out is formed directly from ci rather than through C[1..3].
  assign half_g0 = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
  assign half_p0 = &grp_p[3:0];
  assign half_g1 = grp_g[7] | (grp_p[7] & grp_g[6]) | (grp_p[7] & grp_p[6] & grp_g[5])
                 | (grp_p[7] & grp_p[6] & grp_p[5] & grp_g[4]);
  assign half_p1 = &grp_p[7:4];

  assign grp_c[0] = ci;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & ci);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & ci);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & ci);
  assign grp_c[4] = half_g0 | (half_p0 & ci);
  assign grp_c[5] = grp_g[4] | (grp_p[4] & grp_c[4]);
  assign grp_c[6] = grp_g[5] | (grp_p[5] & grp_g[4]) | (grp_p[5] & grp_p[4] & grp_c[4]);
  assign grp_c[7] = grp_g[6] | (grp_p[6] & grp_g[5]) | (grp_p[6] & grp_p[5] & grp_g[4])
                  | (grp_p[6] & grp_p[5] & grp_p[4] & grp_c[4]);

  assign co = half_g1 | (half_p1 & half_g0) | (half_p1 & half_p0 & ci);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_r  <= '0;
      co_r <= 1'b0;
    end else begin
      s_r  <= s;
      co_r <= co;
    end
  end

endmodule

// File: tb/tb_cla_32bits.sv
// Scoreboard bench for cla_32bits: stimulus pushes expected sums, a monitor
// pops and checks both the combinational and registered outputs each cycle.
module tb_cla_32bits;

  typedef struct packed {
    logic [32:0] sum_exp;
    logic [32:0] reg_exp;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        rst_n;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic [31:0] s;
  logic        co;
  logic [31:0] s_r;
  logic        co_r;

  item_t exp_q[$];
  int    n_tests;
  int    n_fail;
  int    n_popped;
  bit    verbose;

  cla_32bits #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .ci   (ci),
    .s    (s),
    .co   (co),
    .s_r  (s_r),
    .co_r (co_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic r, input logic [31:0] va, input logic [31:0] vb,
                       input logic vci);
    item_t it;
    @(negedge clk);
    rst_n = r;
    a     = va;
    b     = vb;
    ci    = vci;
    it.a       = va;
    it.b       = vb;
    it.ci      = vci;
    it.rst_n   = r;
    it.sum_exp = 33'(va) + 33'(vb) + 33'(vci);
    it.reg_exp = r ? it.sum_exp : 33'd0;
    exp_q.push_back(it);
  endtask

  // Monitor: inputs are stable from negedge through the following posedge,
  // so 1 ns after the posedge both result paths reflect the queued item.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        n_popped++;
        n_tests++;
        if ({co, s} !== it.sum_exp) begin
          n_fail++;
          $display("FAIL comb_sum a=%h b=%h ci=%b: got co=%b s=%h, expected co=%b s=%h",
                   it.a, it.b, it.ci, co, s, it.sum_exp[32], it.sum_exp[31:0]);
        end
        n_tests++;
        if ({co_r, s_r} !== it.reg_exp) begin
          n_fail++;
          $display("FAIL reg_sum rst_n=%b a=%h b=%h ci=%b: got co_r=%b s_r=%h, expected co_r=%b s_r=%h",
                   it.rst_n, it.a, it.b, it.ci, co_r, s_r, it.reg_exp[32], it.reg_exp[31:0]);
        end
        if (verbose)
          $display("[TB] txn rst_n=%b a=%h b=%h ci=%b -> co=%b s=%h co_r=%b s_r=%h",
                   it.rst_n, it.a, it.b, it.ci, co, s, co_r, s_r);
      end
    end
  end

  initial begin
    int n_pushed;
    n_tests  = 0;
    n_fail   = 0;
    n_popped = 0;
    n_pushed = 0;
    verbose  = 1'b1;
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;

    // Directed boundary cases, including reset mid-stream with a live sum.
    apply(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    apply(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    apply(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    apply(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    apply(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    apply(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    apply(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    apply(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    apply(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    apply(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    apply(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    apply(1'b1, 32'h0FFF_FFFF, 32'h0000_0000, 1'b1);
    n_pushed = 12;

    // Random regression with occasional reset pulses.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rci;
      logic        rr;
      if (i == 0) verbose = 1'b0;
      ra  = $urandom;
      rb  = $urandom;
      rci = 1'($urandom_range(0, 1));
      rr  = ($urandom_range(0, 15) != 0);
      // Bias some vectors toward long carry chains.
      if ($urandom_range(0, 7) == 0) rb = ~ra;
      apply(rr, ra, rb, rci);
      n_pushed++;
      if ((i + 1) % 1000 == 0)
        $display("[TB] progress: %0d random vectors applied, %0d failed so far", i + 1, n_fail);
    end

    // Drain with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0 || n_popped != n_pushed) begin
      n_fail++;
      $display("FAIL drain: got %0d checked with %0d pending, expected %0d checked",
               n_popped, exp_q.size(), n_pushed);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
